// File: rtl/fp_mantissa_multiplier_if.sv
// Operand/result bundle for fp_mantissa_multiplier; the requester drives the
// master side and the multiplier sits on the slave side.
interface fp_mantissa_multiplier_if #(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23
);
   logic                              start_in;
   logic                              sign_a_in;
   logic                              sign_b_in;
   logic [EXP_WIDTH-1:0]              exp_a_in;
   logic [EXP_WIDTH-1:0]              exp_b_in;
   logic [MANTISSA_WIDTH-1:0]         mant_a_in;
   logic [MANTISSA_WIDTH-1:0]         mant_b_in;
   logic                              busy_out;
   logic                              done_out;
   logic                              sign_out;
   logic [EXP_WIDTH-1:0]              expoent_out;
   logic [2*(MANTISSA_WIDTH+1)-1:0]   result_out;
   logic                              carry_out;

   modport master (
      output start_in, sign_a_in, sign_b_in, exp_a_in, exp_b_in, mant_a_in, mant_b_in,
      input  busy_out, done_out, sign_out, expoent_out, result_out, carry_out
   );

   modport slave (
      input  start_in, sign_a_in, sign_b_in, exp_a_in, exp_b_in, mant_a_in, mant_b_in,
      output busy_out, done_out, sign_out, expoent_out, result_out, carry_out
   );
endinterface

// File: rtl/fp_mantissa_multiplier.sv
// Sequential shift-and-add significand multiplier with biased exponent sum.
// Define FP_MULT_EARLY_ZERO_EN to skip the multiply for zero/underflow results.
module fp_mantissa_multiplier #(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   fp_mantissa_multiplier_if.slave   bus
);
   localparam int MW = MANTISSA_WIDTH;
   localparam int SW = MW + 1;
   localparam int PW = 2 * SW;
   localparam int CW = $clog2(MW + 2);
   localparam int XW = EXP_WIDTH + 2;
   localparam logic signed [XW-1:0] BIAS = {3'b000, {(EXP_WIDTH-1){1'b1}}};
   localparam logic [CW-1:0] LAST = CW'(SW);

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

   state_t state, next_state;
   logic   accept, load_out;

   logic [CW-1:0]        cnt;
   logic [PW-1:0]        mcand, acc;
   logic [SW-1:0]        mplier;
   logic                 sign_q, carry_q, flush_q;
   logic [EXP_WIDTH-1:0] exp_q;

   logic [SW-1:0]        sig_a, sig_b;
   logic signed [XW-1:0] exp_sum;
   logic                 zero_op, underflow, overflow, flush;

   assign sig_a     = {|bus.exp_a_in, bus.mant_a_in};
   assign sig_b     = {|bus.exp_b_in, bus.mant_b_in};
   assign exp_sum   = $signed({2'b00, bus.exp_a_in}) + $signed({2'b00, bus.exp_b_in}) - BIAS;
   assign zero_op   = (bus.exp_a_in == '0 && bus.mant_a_in == '0) ||
                      (bus.exp_b_in == '0 && bus.mant_b_in == '0);
   assign underflow = exp_sum[XW-1];
   // Non-negative sums never reach 2^(EXP_WIDTH+1), so bit EXP_WIDTH alone flags overflow.
   assign overflow  = ~exp_sum[XW-1] & exp_sum[EXP_WIDTH];
   assign flush     = zero_op | underflow;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= next_state;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      next_state = state;
      accept     = 1'b0;
      load_out   = 1'b0;
      unique case (state)
         IDLE: if (bus.start_in) begin
            accept = 1'b1;
`ifdef FP_MULT_EARLY_ZERO_EN
            if (flush) begin
               next_state = DONE;
               load_out   = 1'b1;
            end else begin
               next_state = MULT;
            end
`else
            next_state = MULT;
`endif
         end
         MULT: if (cnt == LAST) begin
            next_state = DONE;
            load_out   = 1'b1;
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         sign_q  <= 1'b0;
         carry_q <= 1'b0;
         flush_q <= 1'b0;
         exp_q   <= '0;
      end else if (accept) begin
         cnt     <= '0;
         mcand   <= {{SW{1'b0}}, sig_a};
         mplier  <= sig_b;
         acc     <= '0;
         sign_q  <= bus.sign_a_in ^ bus.sign_b_in;
         carry_q <= overflow;
         flush_q <= flush;
         exp_q   <= exp_sum[EXP_WIDTH-1:0];
      end else if (state == MULT && cnt != LAST) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   // Results are published only on entry to DONE and held until the next one.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bus.sign_out    <= 1'b0;
         bus.expoent_out <= '0;
         bus.result_out  <= '0;
         bus.carry_out   <= 1'b0;
      end else if (load_out) begin
         if (state == IDLE) begin
            bus.sign_out    <= bus.sign_a_in ^ bus.sign_b_in;
            bus.expoent_out <= '0;
            bus.result_out  <= '0;
            bus.carry_out   <= 1'b0;
         end else begin
            bus.sign_out    <= sign_q;
            bus.expoent_out <= flush_q ? '0 : exp_q;
            bus.result_out  <= flush_q ? '0 : acc;
            bus.carry_out   <= flush_q ? 1'b0 : carry_q;
         end
      end
   end

   assign bus.busy_out = (state != IDLE);
   assign bus.done_out = (state == DONE);
endmodule

// File: tb/tb_fp_mantissa_multiplier.sv
// Self-checking bench for fp_mantissa_multiplier: directed cases plus random
// operands against an arithmetic reference model.
module tb_fp_mantissa_multiplier;
   localparam int EW   = 8;
   localparam int MW   = 23;
   localparam int PW   = 2 * (MW + 1);
   localparam int BIAS = (1 << (EW - 1)) - 1;
   localparam int LAT  = MW + 2;
`ifdef FP_MULT_EARLY_ZERO_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   int   total = 0;
   int   bad = 0;

   fp_mantissa_multiplier_if #(.EXP_WIDTH(EW), .MANTISSA_WIDTH(MW)) bus ();

   fp_mantissa_multiplier #(.EXP_WIDTH(EW), .MANTISSA_WIDTH(MW)) dut (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .bus     (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: real significand product and integer exponent arithmetic.
   task automatic model(input int ea, input int eb, input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                        output logic [PW-1:0] r, output logic [EW-1:0] e, output logic c,
                        output logic fl);
      longint ga, gb;
      int     es;
      ga = longint'(ma) + ((ea != 0) ? (longint'(1) << MW) : 0);
      gb = longint'(mb) + ((eb != 0) ? (longint'(1) << MW) : 0);
      es = ea + eb - BIAS;
      fl = ((ea == 0) && (ma == 0)) || ((eb == 0) && (mb == 0)) || (es < 0);
      if (fl) begin
         r = '0; e = '0; c = 1'b0;
      end else begin
         r = PW'(ga * gb);
         e = EW'(es % (1 << EW));
         c = (es >= (1 << EW));
      end
   endtask

   task automatic drive(input logic sa, input logic sb, input int ea, input int eb,
                        input logic [MW-1:0] ma, input logic [MW-1:0] mb);
      bus.sign_a_in = sa;
      bus.sign_b_in = sb;
      bus.exp_a_in  = EW'(ea);
      bus.exp_b_in  = EW'(eb);
      bus.mant_a_in = ma;
      bus.mant_b_in = mb;
   endtask

   task automatic run_op(input string tag, input logic sa, input logic sb, input int ea, input int eb,
                         input logic [MW-1:0] ma, input logic [MW-1:0] mb);
      logic [PW-1:0] r;
      logic [EW-1:0] e;
      logic          c, fl;
      int            lat;
      model(ea, eb, ma, mb, r, e, c, fl);
      @(negedge clk_in);
      drive(sa, sb, ea, eb, ma, mb);
      bus.start_in = 1'b1;
      @(posedge clk_in);
      #1 bus.start_in = 1'b0;
      lat = 0;
      while (!bus.done_out && lat < 100) begin
         @(posedge clk_in);
         #1 lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'((EARLY && fl) ? 0 : LAT));
      check({tag, "_result"}, 64'(bus.result_out), 64'(r));
      check({tag, "_exp"}, 64'(bus.expoent_out), 64'(e));
      check({tag, "_carry"}, 64'(bus.carry_out), 64'(c));
      check({tag, "_sign"}, 64'(bus.sign_out), 64'(sa ^ sb));
      check({tag, "_busy"}, 64'(bus.busy_out), 64'(1));
      drive(~sa, sb, 3, 250, '1, 5);
      @(posedge clk_in);
      #1;
      check({tag, "_done_pulse"}, 64'(bus.done_out), 64'(0));
      check({tag, "_hold"}, 64'(bus.result_out), 64'(r));
   endtask

   initial begin
      logic [PW-1:0] r;
      logic [EW-1:0] e;
      logic          c, fl;
      int            n_done;
      logic [PW-1:0] seen;

      bus.start_in = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_busy", 64'(bus.busy_out), 64'(0));
      check("rst_done", 64'(bus.done_out), 64'(0));
      check("rst_result", 64'(bus.result_out), 64'(0));
      check("rst_exp", 64'(bus.expoent_out), 64'(0));
      check("rst_carry", 64'(bus.carry_out), 64'(0));
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Hand-worked cases: result_out literals are the known products.
      run_op("one_x_one", 0, 0, 127, 127, 0, 0);
      check("one_x_one_literal", 64'(bus.result_out), 64'h4000_0000_0000);
      run_op("p15_x_m15", 0, 1, 127, 127, 23'h400000, 23'h400000);
      check("p15_x_m15_literal", 64'(bus.result_out), 64'h9000_0000_0000);
      run_op("overflow", 0, 0, 200, 200, 23'h123456, 23'h654321);
      check("overflow_exp_literal", 64'(bus.expoent_out), 64'd17);
      run_op("underflow", 1, 0, 10, 10, 23'h7fffff, 23'h1);
      run_op("zero_a", 1, 0, 0, 150, 0, 23'h2aaaaa);
      run_op("zero_b", 0, 1, 140, 0, 23'h555555, 0);
      run_op("denorm", 0, 0, 0, 200, 23'h400001, 23'h7fffff);
      run_op("exp_bias_edge", 0, 0, 1, 126, 23'h7fffff, 23'h7fffff);
      run_op("exp_max", 1, 1, 255, 255, 23'h7fffff, 23'h7fffff);

      for (int i = 0; i < 16; i++) begin
         int ea, eb;
         ea = $urandom_range(0, 255);
         eb = $urandom_range(0, 255);
         if (i % 5 == 4) ea = 0;
         run_op("rand", 1'($urandom), 1'($urandom), ea, eb,
                MW'($urandom) & ((i % 5 == 4) ? '0 : '1), MW'($urandom));
      end

      // A second start during MULT must be ignored.
      model(127, 127, 23'h400000, 23'h400000, r, e, c, fl);
      @(negedge clk_in);
      drive(0, 0, 127, 127, 23'h400000, 23'h400000);
      bus.start_in = 1'b1;
      @(posedge clk_in);
      #1 bus.start_in = 1'b0;
      repeat (5) @(posedge clk_in);
      @(negedge clk_in);
      drive(1, 0, 200, 200, 23'h7fffff, 23'h1);
      bus.start_in = 1'b1;
      @(posedge clk_in);
      #1 bus.start_in = 1'b0;
      n_done = 0;
      seen = '0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_in);
         #1;
         if (bus.done_out) begin
            n_done++;
            seen = bus.result_out;
         end
      end
      check("restart_ignored_dones", 64'(n_done), 64'(1));
      check("restart_ignored_result", 64'(seen), 64'(r));
      check("restart_ignored_exp", 64'(bus.expoent_out), 64'(e));
      check("restart_ignored_carry", 64'(bus.carry_out), 64'(c));
      check("restart_ignored_sign", 64'(bus.sign_out), 64'(0));

      // Reset five cycles into MULT aborts silently.
      @(negedge clk_in);
      drive(0, 0, 127, 127, 0, 0);
      bus.start_in = 1'b1;
      @(posedge clk_in);
      #1 bus.start_in = 1'b0;
      repeat (5) @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy_out), 64'(0));
      check("abort_done", 64'(bus.done_out), 64'(0));
      check("abort_result", 64'(bus.result_out), 64'(0));
      check("abort_exp", 64'(bus.expoent_out), 64'(0));
      check("abort_sign", 64'(bus.sign_out), 64'(0));
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
      n_done = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk_in);
         #1;
         if (bus.done_out) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'(0));
      run_op("after_abort", 0, 0, 127, 127, 0, 0);
      check("after_abort_literal", 64'(bus.result_out), 64'h4000_0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_mantissa_multiplier.md
FP_MANTISSA_MULTIPLIER -- requirements
Module: fp_mantissa_multiplier

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, stored fraction width (MW); hidden bit is added internally.
REQ-003 SHALL have port clk_in  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_in  input  1  request; accepted only in IDLE.
REQ-006 SHALL have ports sign_a_in/sign_b_in  input  1  operand signs.
REQ-007 SHALL have ports exp_a_in/exp_b_in  input  EXP_WIDTH  biased operand exponents.
REQ-008 SHALL have ports mant_a_in/mant_b_in  input  MW  operand fractions.
REQ-009 SHALL have port busy_out  output  1  high in MULT and DONE.
REQ-010 SHALL have port done_out  output  1  one-cycle pulse, results valid.
REQ-011 SHALL have port sign_out  output  1  sign_a XOR sign_b.
REQ-012 SHALL have port expoent_out  output  EXP_WIDTH  biased sum exponent for the downstream normalizer.
REQ-013 SHALL have port result_out  output  2*(MW+1)  unnormalized mantissa product.
REQ-014 SHALL have port carry_out  output  1  exponent overflow flag.

Function
REQ-015 SHALL implement FSM IDLE -> MULT -> DONE -> IDLE.
REQ-016 In IDLE with start_in=1 at an edge, SHALL latch operands, form significands {hidden,mant} with hidden=(exp!=0), clear accumulator, enter MULT.
REQ-017 start_in SHALL be ignored in MULT and DONE.
REQ-018 MULT SHALL perform one shift-and-add step per cycle, exactly MW+1 cycles, using an iteration counter of width ceil(log2(MW+2)).
REQ-019 After the last step SHALL enter DONE; done_out=1 for exactly that one cycle; next edge returns to IDLE.
REQ-020 Latency: done_out SHALL be high in the cycle beginning MW+2 rising edges after the edge that accepted start_in (25 for defaults).
REQ-021 Exponent SHALL be exp_a+exp_b-BIAS, BIAS=2^(EXP_WIDTH-1)-1, computed in EXP_WIDTH+2 signed bits.
REQ-022 Sum >= 2^EXP_WIDTH: carry_out=1, expoent_out=low EXP_WIDTH bits.
REQ-023 Sum < 0: flush-to-zero -- expoent_out=0, result_out=0, carry_out=0.
REQ-024 Either operand with exp=0 and mant=0: result_out=0, expoent_out=0, carry_out=0, sign_out still XOR.
REQ-025 Outputs SHALL update only on entry to DONE and hold until the next DONE or reset.

Reset
REQ-026 rst_n_in low SHALL immediately force IDLE, counter 0, accumulator 0, and all outputs 0.
REQ-027 Reset mid-MULT SHALL abort without a done_out pulse; first edge after release accepts a new start.

Configuration
REQ-028 Macro FP_MULT_EARLY_ZERO_EN, when defined: zero operand (REQ-024) or underflow (REQ-023) at acceptance SHALL go IDLE -> DONE directly, done_out one cycle after the accepting edge.
REQ-029 Without the macro, all operations SHALL take the full REQ-020 latency; zero/underflow results are identical either way.

Verification
REQ-030 1.0*1.0 (exp 127, mant 0 each) -> result_out=0x4000_0000_0000, expoent_out=127, carry_out=0, done_out 25 cycles after start.
REQ-031 1.5*-1.5 (mant 0x400000, exp 127) -> result_out=0x9000_0000_0000 (bit 47 set), expoent_out=127, sign_out=1.
REQ-032 exp 200 and 200 -> carry_out=1, expoent_out=17.
REQ-033 exp 10 and 10 -> result_out=0, expoent_out=0, carry_out=0; with FP_MULT_EARLY_ZERO_EN done_out after 1 cycle, without after 25.
REQ-034 Second start_in pulse during MULT -> ignored, one done_out, results of first operands only.
REQ-035 rst_n_in low 5 cycles into MULT -> outputs 0, busy_out 0, no done_out; restart 1.0*1.0 -> REQ-030 response.
